// File: rtl/saes_decrypt_core.sv
// Iterative S-AES decryption core: expands the key, then walks the inverse rounds one step per clock.
// A last-key cache lets a block with a repeated key skip the expansion step.
`timescale 1ns/1ps
module saes_decrypt_core #(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_ciphertext,
  input  logic [15:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_plaintext,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, KEYX, RND2, RND1, FIN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] st_q, st_d;
  logic [15:0] k0_q, k0_d;
  logic [15:0] k1_q, k1_d;
  logic [15:0] k2_q, k2_d;
  logic [15:0] cache_key_q, cache_key_d;
  logic        cache_vld_q, cache_vld_d;
  logic [15:0] pt_q, pt_d;
  logic        ovalid_q, ovalid_d;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
      4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
      4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
      4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
      4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
    endcase
    return r;
  endfunction

  // GF(2^4) doubling, reduction polynomial x^4 + x + 1.
  function automatic logic [3:0] gf_mul2(input logic [3:0] n);
    return {n[2:0], 1'b0} ^ (n[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_mul9(input logic [3:0] n);
    return gf_mul2(gf_mul2(gf_mul2(n))) ^ n;
  endfunction

  function automatic logic [15:0] inv_sub(input logic [15:0] s);
    return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
  endfunction

  function automatic logic [15:0] inv_shift(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [15:0] inv_mix(input logic [15:0] s);
    return {gf_mul9(s[15:12]) ^ gf_mul2(s[11:8]),
            gf_mul2(s[15:12]) ^ gf_mul9(s[11:8]),
            gf_mul9(s[7:4])   ^ gf_mul2(s[3:0]),
            gf_mul2(s[7:4])   ^ gf_mul9(s[3:0])};
  endfunction

  // RotNib then forward SubNib, folded with the round constant.
  function automatic logic [7:0] key_g(input logic [7:0] w, input logic [7:0] rcon);
    return rcon ^ {sbox(w[3:0]), sbox(w[7:4])};
  endfunction

  logic [7:0] w2, w3, w4, w5;
  logic       key_hit;

  assign w2 = k0_q[15:8] ^ key_g(k0_q[7:0], 8'h80);
  assign w3 = w2 ^ k0_q[7:0];
  assign w4 = w2 ^ key_g(w3, 8'h30);
  assign w5 = w4 ^ w3;

  assign key_hit = KEY_REUSE && cache_vld_q && (in_key == cache_key_q);

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    k0_d        = k0_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    pt_d        = pt_q;
    ovalid_d    = ovalid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_ciphertext;
          k0_d    = in_key;
          state_d = key_hit ? RND2 : KEYX;
        end
      end
      KEYX: begin
        k1_d        = {w2, w3};
        k2_d        = {w4, w5};
        cache_key_d = k0_q;
        cache_vld_d = 1'b1;
        state_d     = RND2;
      end
      RND2: begin
        st_d    = inv_sub(inv_shift(st_q ^ k2_q));
        state_d = RND1;
      end
      RND1: begin
        st_d    = inv_sub(inv_shift(inv_mix(st_q ^ k1_q)));
        state_d = FIN;
      end
      FIN: begin
        pt_d     = st_q ^ k0_q;
        ovalid_d = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      k0_q        <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      pt_q        <= '0;
      ovalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      pt_q        <= pt_d;
      ovalid_q    <= ovalid_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign out_valid     = ovalid_q;
  assign out_plaintext = pt_q;

endmodule

// File: tb/tb_saes_decrypt_core.sv
// Bench for saes_decrypt_core: known-answer table, key-cache latency, backpressure, abort and
// random round trips against an independent S-AES encryption model.
`timescale 1ns/1ps
module tb_saes_decrypt_core;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
  logic [1:0][15:0] ct_v, key_v, pt_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  saes_decrypt_core #(.KEY_REUSE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_ciphertext(ct_v[0]), .in_key(key_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_plaintext(pt_v[0]), .busy(busy_v[0])
  );

  saes_decrypt_core #(.KEY_REUSE(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_ciphertext(ct_v[1]), .in_key(key_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_plaintext(pt_v[1]), .busy(busy_v[1])
  );

  localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] s);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = SBOX[s[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [15:0] enc(input logic [15:0] pt, input logic [15:0] key);
    logic [7:0]  w2, w3, w4, w5;
    logic [15:0] s;
    w2 = key[15:8] ^ 8'h80 ^ {SBOX[key[3:0]], SBOX[key[7:4]]};
    w3 = w2 ^ key[7:0];
    w4 = w2 ^ 8'h30 ^ {SBOX[w3[3:0]], SBOX[w3[7:4]]};
    w5 = w4 ^ w3;
    s = sub16(pt ^ key);
    s = {s[15:12], s[3:0], s[7:4], s[11:8]};
    s = {s[15:12] ^ gmul(4'h4, s[11:8]), gmul(4'h4, s[15:12]) ^ s[11:8],
         s[7:4] ^ gmul(4'h4, s[3:0]),    gmul(4'h4, s[7:4]) ^ s[3:0]};
    s = sub16(s ^ {w2, w3});
    s = {s[15:12], s[3:0], s[7:4], s[11:8]};
    return s ^ {w4, w5};
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Offers one block and returns once out_valid is seen; lat counts edges from the
  // acceptance edge (inclusive) to the edge on which out_valid rises.
  task automatic offer(input int sel, input logic [15:0] ct, input logic [15:0] key,
                       output int lat, output bit ok);
    int guard;
    ok = 1'b0;
    lat = 0;
    ct_v[sel] = ct;
    key_v[sel] = key;
    in_valid_v[sel] = 1'b1;
    guard = 0;
    while (!in_ready_v[sel] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready_v[sel]) begin
      in_valid_v[sel] = 1'b0;
      chk1("accept_timeout", in_ready_v[sel], 1'b1);
      return;
    end
    @(posedge clk); #1;
    in_valid_v[sel] = 1'b0;
    ct_v[sel] = ~ct;
    key_v[sel] = ~key;
    lat = 1;
    while (!out_valid_v[sel] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid_v[sel]) begin
      chk1("out_valid_timeout", out_valid_v[sel], 1'b1);
      return;
    end
    ok = 1'b1;
  endtask

  task automatic drain(input int sel);
    int guard;
    guard = 0;
    while (out_valid_v[sel] && guard < 40) begin
      out_ready_v[sel] = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      guard++;
    end
    out_ready_v[sel] = 1'b1;
    if (out_valid_v[sel]) chk1("drain_timeout", out_valid_v[sel], 1'b0);
  endtask

  typedef struct {
    logic [15:0] ct;
    logic [15:0] key;
    logic [15:0] pt;
    int          lat;
    bit          by_enc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat;
    bit          ok;
    int          nidle;
    logic [15:0] got, rpt, rkey, rct, last_key;

    vecs[0] = '{ct: 16'h0738, key: 16'hA73B, pt: 16'h6F6B, lat: 5, by_enc: 1'b0};
    vecs[1] = '{ct: 16'h24EC, key: 16'h4AF5, pt: 16'hD728, lat: 5, by_enc: 1'b0};
    vecs[2] = '{ct: 16'h24EC, key: 16'h4AF5, pt: 16'hD728, lat: 4, by_enc: 1'b0};
    vecs[3] = '{ct: 16'h0000, key: 16'h0000, pt: 16'h0000, lat: 5, by_enc: 1'b1};
    vecs[4] = '{ct: 16'h0738, key: 16'hA73B, pt: 16'h6F6B, lat: 5, by_enc: 1'b0};
    vecs[5] = '{ct: 16'h0738, key: 16'hA73B, pt: 16'h6F6B, lat: 4, by_enc: 1'b0};

    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready_v = '1;
    ct_v = '0;
    key_v = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready_v[0], 1'b1);
    chk1("rst_out_valid", out_valid_v[0], 1'b0);
    chk1("rst_busy", busy_v[0], 1'b0);
    chk16("rst_plaintext", pt_v[0], 16'h0000);
    rst_n = 1'b1;

    // Known answers and cache-hit latency, out_ready held high.
    for (int v = 0; v < 6; v++) begin
      offer(0, vecs[v].ct, vecs[v].key, lat, ok);
      if (ok) begin
        chk16($sformatf("vec%0d_latency", v), 16'(lat), 16'(vecs[v].lat));
        if (vecs[v].by_enc) chk16($sformatf("vec%0d_reenc", v), enc(pt_v[0], vecs[v].key), vecs[v].ct);
        else                chk16($sformatf("vec%0d_plaintext", v), pt_v[0], vecs[v].pt);
        @(posedge clk); #1;
        chk1($sformatf("vec%0d_in_ready_after", v), in_ready_v[0], 1'b1);
        chk1($sformatf("vec%0d_valid_cleared", v), out_valid_v[0], 1'b0);
      end
    end

    // KEY_REUSE=0 instance always expands.
    for (int r = 0; r < 2; r++) begin
      offer(1, 16'h24EC, 16'h4AF5, lat, ok);
      if (ok) begin
        chk16($sformatf("noreuse%0d_latency", r), 16'(lat), 16'd5);
        chk16($sformatf("noreuse%0d_plaintext", r), pt_v[1], 16'hD728);
        @(posedge clk); #1;
      end
    end

    // Backpressure: output held, handshake input ignored.
    out_ready_v[0] = 1'b0;
    offer(0, 16'h0738, 16'hA73B, lat, ok);
    if (ok) begin
      chk16("bp_latency", 16'(lat), 16'd4);
      for (int c = 0; c < 10; c++) begin
        chk1("bp_out_valid", out_valid_v[0], 1'b1);
        chk16("bp_plaintext", pt_v[0], 16'h6F6B);
        chk1("bp_in_ready", in_ready_v[0], 1'b0);
        chk1("bp_busy", busy_v[0], 1'b1);
        in_valid_v[0] = c[0];
        ct_v[0] = 16'($urandom);
        key_v[0] = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid_v[0] = 1'b0;
      out_ready_v[0] = 1'b1;
      @(posedge clk); #1;
      chk1("bp_release_valid", out_valid_v[0], 1'b0);
      chk1("bp_release_ready", in_ready_v[0], 1'b1);
      @(posedge clk); #1;
      chk1("bp_no_extra_block", busy_v[0], 1'b0);
    end

    // Abort in RND1 on a cache-hit block; the cache must not survive reset.
    ct_v[0] = 16'h0738;
    key_v[0] = 16'hA73B;
    in_valid_v[0] = 1'b1;
    chk1("abort_ready_pre", in_ready_v[0], 1'b1);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    chk1("abort_busy_rnd2", busy_v[0], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk1("abort_out_valid", out_valid_v[0], 1'b0);
    chk16("abort_plaintext", pt_v[0], 16'h0000);
    chk1("abort_busy", busy_v[0], 1'b0);
    chk1("abort_in_ready", in_ready_v[0], 1'b1);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk1("abort_no_output", out_valid_v[0], 1'b0);
    offer(0, 16'h0738, 16'hA73B, lat, ok);
    if (ok) begin
      chk16("post_abort_latency", 16'(lat), 16'd5);
      chk16("post_abort_plaintext", pt_v[0], 16'h6F6B);
      @(posedge clk); #1;
    end

    // Every nibble value through the datapath.
    for (int n = 0; n < 16; n++) begin
      rpt = {4{4'(n)}};
      rkey = {4'(n), ~4'(n), 4'(n) ^ 4'h5, 4'(15 - n)};
      offer(0, enc(rpt, rkey), rkey, lat, ok);
      if (ok) begin
        chk16($sformatf("nibble%0d_roundtrip", n), pt_v[0], rpt);
        @(posedge clk); #1;
      end
    end

    // Random round trips with throttled handshakes and frequent key reuse.
    last_key = 16'h1234;
    for (int b = 0; b < 200; b++) begin
      rpt = 16'($urandom);
      rkey = ($urandom_range(0, 1) == 1) ? last_key : 16'($urandom);
      last_key = rkey;
      rct = enc(rpt, rkey);
      nidle = $urandom_range(0, 3);
      repeat (nidle) begin
        @(posedge clk); #1;
      end
      out_ready_v[0] = ($urandom_range(0, 1) == 1);
      offer(0, rct, rkey, lat, ok);
      if (ok) begin
        got = pt_v[0];
        drain(0);
        chk16($sformatf("random%0d_roundtrip", b), got, rpt);
      end else begin
        out_ready_v[0] = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
